// File: rtl/xoodyak_op_sequencer_if.sv
// Handshake and core-control bundle between the AEAD op sequencer and its environment.
// master = sequencer side, slave = environment side (request source, block source/sink, core).
// All block and tag buses are carried flat; CW sizes the per-request block counters.
interface xoodyak_op_sequencer_if #(
   parameter int CW = 6
);
   logic          req_valid;
   logic          req_ready;
   logic          req_decrypt;
   logic [CW-1:0] req_ad_blks;
   logic [CW-1:0] req_msg_blks;
   logic [127:0]  req_tag;

   logic          blk_valid;
   logic [191:0]  blk_data;
   logic          blk_ready;

   logic          out_valid;
   logic [191:0]  out_data;
   logic          out_ready;

   logic [3:0]    core_opmode;
   logic          core_start;
   logic [191:0]  core_textin;
   logic [191:0]  core_textout;
   logic          core_finished;

   logic          tag_valid;
   logic [127:0]  tag_out;
   logic          auth_ok;
   logic          err_timeout;

   modport master (
      input  req_valid, req_decrypt, req_ad_blks, req_msg_blks, req_tag,
      input  blk_valid, blk_data, out_ready, core_textout, core_finished,
      output req_ready, blk_ready, out_valid, out_data,
      output core_opmode, core_start, core_textin,
      output tag_valid, tag_out, auth_ok, err_timeout
   );

   modport slave (
      output req_valid, req_decrypt, req_ad_blks, req_msg_blks, req_tag,
      output blk_valid, blk_data, out_ready, core_textout, core_finished,
      input  req_ready, blk_ready, out_valid, out_data,
      input  core_opmode, core_start, core_textin,
      input  tag_valid, tag_out, auth_ok, err_timeout
   );
endinterface

// File: rtl/xoodyak_op_sequencer.sv
// Walks the Xoodyak core through init/nonce/AD/crypt/squeeze for one AEAD request and checks the tag.
// Latency: accept->first start 1 cycle; finish->next start 1 cycle; block accept->crypt start 1 cycle.
// Backpressure: one result block outstanding; next block is fetched only after out_ready takes the last one.
module xoodyak_op_sequencer #(
   parameter int CW  = 6,
   parameter int TMO = 255
) (
   input logic                    eph1,
   input logic                    reset,
   xoodyak_op_sequencer_if.master bus
);

   localparam int TW = $clog2(TMO + 1);

   localparam logic [2:0] OP_INIT  = 3'd1;
   localparam logic [2:0] OP_NONCE = 3'd2;
   localparam logic [2:0] OP_ASSOC = 3'd3;
   localparam logic [2:0] OP_ENC   = 3'd4;
   localparam logic [2:0] OP_DEC   = 3'd5;
   localparam logic [2:0] OP_SQZ   = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FETCH,
      S_DRAIN,
      S_TAG
   } state_t;

   state_t          state_q;

   // latched request
   logic            dec_q;
   logic [CW-1:0]   ad_blks_q;
   logic [CW-1:0]   msg_blks_q;
   logic [127:0]    req_tag_q;

   // progress counters
   logic [CW-1:0]   ad_cnt_q;
   logic [CW-1:0]   msg_cnt_q;
   logic [TW-1:0]   tmo_cnt_q;
   logic [CW:0]     ad_cnt_d;
   logic [CW:0]     msg_cnt_d;
   logic [TW-1:0]   tmo_cnt_d;

   // registered outputs; core_opmode_q[2:0] doubles as the current phase
   logic            req_ready_q;
   logic            blk_ready_q;
   logic            out_valid_q;
   logic [191:0]    out_data_q;
   logic [3:0]      core_opmode_q;
   logic            core_start_q;
   logic [191:0]    core_textin_q;
   logic            tag_valid_q;
   logic [127:0]    tag_out_q;
   logic            auth_ok_q;
   logic            err_timeout_q;

   // Incremented counters, one bit wider for block counts so the limit compare never wraps.
   always_comb begin
      ad_cnt_d  = {1'b0, ad_cnt_q} + 1'b1;
      msg_cnt_d = {1'b0, msg_cnt_q} + 1'b1;
      tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   // Phase sequencer: state, counters and every output register.
   always_ff @(posedge eph1 or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         dec_q         <= 1'b0;
         ad_blks_q     <= '0;
         msg_blks_q    <= '0;
         req_tag_q     <= '0;
         ad_cnt_q      <= '0;
         msg_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         req_ready_q   <= 1'b0;
         blk_ready_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         core_opmode_q <= '0;
         core_start_q  <= 1'b0;
         core_textin_q <= '0;
         tag_valid_q   <= 1'b0;
         tag_out_q     <= '0;
         auth_ok_q     <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         core_start_q <= 1'b0;
         tag_valid_q  <= 1'b0;
         auth_ok_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               core_opmode_q <= '0;
               req_ready_q   <= 1'b1;
               if (bus.req_valid && req_ready_q) begin
                  req_ready_q   <= 1'b0;
                  dec_q         <= bus.req_decrypt;
                  ad_blks_q     <= bus.req_ad_blks;
                  msg_blks_q    <= bus.req_msg_blks;
                  req_tag_q     <= bus.req_tag;
                  ad_cnt_q      <= '0;
                  msg_cnt_q     <= '0;
                  err_timeout_q <= 1'b0;
                  core_opmode_q <= {1'b0, OP_INIT};
                  core_start_q  <= 1'b1;
                  state_q       <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               tmo_cnt_q <= '0;
               state_q   <= S_WAIT;
            end

            S_WAIT: begin
               if (bus.core_finished) begin
                  case (core_opmode_q[2:0])
                     OP_INIT: begin
                        core_opmode_q <= {1'b0, OP_NONCE};
                        core_start_q  <= 1'b1;
                        state_q       <= S_ISSUE;
                     end
                     OP_NONCE, OP_ASSOC: begin
                        // ad_cnt_d only meaningful after an ASSOC phase; NONCE starts the AD walk
                        if (core_opmode_q[2:0] == OP_ASSOC)
                           ad_cnt_q <= ad_cnt_d[CW-1:0];
                        if ((core_opmode_q[2:0] == OP_NONCE && ad_blks_q != '0) ||
                            (core_opmode_q[2:0] == OP_ASSOC && ad_cnt_d < {1'b0, ad_blks_q})) begin
                           core_opmode_q <= {(core_opmode_q[2:0] == OP_ASSOC), OP_ASSOC};
                           core_start_q  <= 1'b1;
                           state_q       <= S_ISSUE;
                        end else if (msg_blks_q != '0) begin
                           blk_ready_q <= 1'b1;
                           state_q     <= S_FETCH;
                        end else begin
                           core_opmode_q <= {1'b0, OP_SQZ};
                           core_start_q  <= 1'b1;
                           state_q       <= S_ISSUE;
                        end
                     end
                     OP_ENC, OP_DEC: begin
                        out_data_q  <= bus.core_textout;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DRAIN;
                     end
                     OP_SQZ: begin
                        tag_out_q   <= bus.core_textout[127:0];
                        tag_valid_q <= 1'b1;
                        auth_ok_q   <= dec_q && (bus.core_textout[127:0] == req_tag_q);
                        state_q     <= S_TAG;
                     end
                     default: begin
                        core_opmode_q <= '0;
                        req_ready_q   <= 1'b1;
                        state_q       <= S_IDLE;
                     end
                  endcase
               end else if (tmo_cnt_q == TW'(TMO - 1)) begin
                  err_timeout_q <= 1'b1;
                  out_valid_q   <= 1'b0;
                  blk_ready_q   <= 1'b0;
                  core_opmode_q <= '0;
                  req_ready_q   <= 1'b1;
                  state_q       <= S_IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_d;
               end
            end

            S_FETCH: begin
               if (bus.blk_valid) begin
                  core_textin_q <= bus.blk_data;
                  blk_ready_q   <= 1'b0;
                  core_opmode_q <= {(msg_cnt_q != '0), (dec_q ? OP_DEC : OP_ENC)};
                  core_start_q  <= 1'b1;
                  state_q       <= S_ISSUE;
               end
            end

            S_DRAIN: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  msg_cnt_q   <= msg_cnt_d[CW-1:0];
                  if (msg_cnt_d < {1'b0, msg_blks_q}) begin
                     blk_ready_q <= 1'b1;
                     state_q     <= S_FETCH;
                  end else begin
                     core_opmode_q <= {1'b0, OP_SQZ};
                     core_start_q  <= 1'b1;
                     state_q       <= S_ISSUE;
                  end
               end
            end

            S_TAG: begin
               core_opmode_q <= '0;
               req_ready_q   <= 1'b1;
               state_q       <= S_IDLE;
            end

            default: begin
               core_opmode_q <= '0;
               state_q       <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.blk_ready   = blk_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.core_opmode = core_opmode_q;
   assign bus.core_start  = core_start_q;
   assign bus.core_textin = core_textin_q;
   assign bus.tag_valid   = tag_valid_q;
   assign bus.tag_out     = tag_out_q;
   assign bus.auth_ok     = auth_ok_q;
   assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_xoodyak_op_sequencer.sv
// Bench for xoodyak_op_sequencer: behavioural core model plus request/block/result drivers.
// Expected opmode sequences, result blocks and tags come from the AEAD phase rules.
// Inputs change and outputs are sampled on the falling edge of eph1.
`timescale 1ns/1ps
module tb_xoodyak_op_sequencer;

   localparam int CW  = 6;
   localparam int TMO = 255;
   localparam int LAT = 12;
   localparam logic [191:0] CMASK    = 192'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_0112233445566778;
   localparam logic [63:0]  SQ_HI    = 64'h5a5a_1234_a5a5_4321;
   localparam logic [127:0] TAG_SEED = 128'hc001d00d_5eed1234_a5a5f00d_0badcafe;
   localparam logic [191:0] BLK_TP   = 192'h4d4e4f505152535455565758_4142434445464748494a4b4c;

   logic eph1 = 1'b0;
   logic reset;

   xoodyak_op_sequencer_if #(.CW(CW)) bus ();

   xoodyak_op_sequencer #(.CW(CW), .TMO(TMO)) dut (
      .eph1  (eph1),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 eph1 = ~eph1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [191:0] blocks [0:7];

   // core model controls
   bit           hang_nonce = 1'b0;
   bit           cm_kill    = 1'b0;
   int           cm_cnt     = 0;
   logic [191:0] cm_res;
   logic [127:0] cm_acc;
   logic [3:0]   op_log [$];

   // Behavioural core: finishes LAT cycles after each start; crypt = textin ^ CMASK, squeeze = seed ^ crypt inputs.
   always @(negedge eph1) begin
      bus.core_finished = 1'b0;
      if (cm_kill) cm_cnt = 0;
      if (cm_cnt > 0) begin
         cm_cnt--;
         if (cm_cnt == 0) begin
            bus.core_finished = 1'b1;
            bus.core_textout  = cm_res;
         end
      end
      if (bus.core_start === 1'b1 && !cm_kill) begin
         op_log.push_back(bus.core_opmode);
         case (bus.core_opmode[2:0])
            3'd1:       begin cm_acc = TAG_SEED; cm_res = '0; end
            3'd4, 3'd5: begin cm_acc = cm_acc ^ bus.core_textin[127:0]; cm_res = bus.core_textin ^ CMASK; end
            3'd6:       cm_res = {SQ_HI, cm_acc};
            default:    cm_res = {188'h0, bus.core_opmode};
         endcase
         if (!(hang_nonce && bus.core_opmode[2:0] == 3'd2)) cm_cnt = LAT;
      end
   end

   function automatic logic [127:0] calc_tag(input int msg);
      logic [127:0] t;
      t = TAG_SEED;
      for (int i = 0; i < msg; i++) t = t ^ blocks[i][127:0];
      return t;
   endfunction

   task automatic rand_blocks();
      for (int i = 0; i < 8; i++)
         blocks[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic run_txn(input bit dec, input int ad, input int msg, input logic [127:0] rtag,
                          input bit rnd, input bit stall, input bit abort);
      logic [191:0] exp_out [$];
      logic [3:0]   exp_ops [$];
      logic [127:0] exp_tag;
      logic [191:0] held;
      logic         exp_auth;
      logic         any_out;
      int bi, oi, nblk, ntag, extra_rdy, cyc, stall_cnt, stall_bad, since_xfer, start_lat;
      bit done, seen_tag, ops_ok;

      exp_tag  = calc_tag(msg);
      exp_auth = dec && (rtag == exp_tag);
      for (int i = 0; i < msg; i++) exp_out.push_back(blocks[i] ^ CMASK);
      exp_ops.push_back(4'h1);
      exp_ops.push_back(4'h2);
      for (int a = 0; a < ad; a++) exp_ops.push_back(a == 0 ? 4'h3 : 4'hB);
      for (int m = 0; m < msg; m++) exp_ops.push_back({(m != 0), (dec ? 3'd5 : 3'd4)});
      exp_ops.push_back(4'h6);

      bi = 0; oi = 0; nblk = 0; ntag = 0; extra_rdy = 0; stall_cnt = 0; stall_bad = 0;
      since_xfer = -1; start_lat = -1; done = 0; seen_tag = 0; held = '0;

      @(negedge eph1);
      cyc = 0;
      while (bus.req_ready !== 1'b1 && cyc < 50) begin @(negedge eph1); cyc++; end
      op_log.delete();
      bus.req_valid    = 1'b1;
      bus.req_decrypt  = dec;
      bus.req_ad_blks  = CW'(ad);
      bus.req_msg_blks = CW'(msg);
      bus.req_tag      = rtag;
      @(negedge eph1);
      bus.req_valid    = 1'b0;
      bus.req_decrypt  = ~dec;
      bus.req_ad_blks  = '1;
      bus.req_msg_blks = '1;
      bus.req_tag      = ~rtag;
      n_checks++;
      if (bus.core_start !== 1'b1 || bus.core_opmode !== 4'h1 || bus.req_ready !== 1'b0)
         $display("FAIL accept_latency start=%b opmode=%h req_ready=%b, need 1/1/0", bus.core_start, bus.core_opmode, bus.req_ready);
      else n_pass++;
      n_checks++;
      if (bus.err_timeout !== 1'b0) $display("FAIL err_cleared_on_accept got %b need 0", bus.err_timeout);
      else n_pass++;

      cyc = 0;
      while (!done && cyc < 4000) begin
         if (since_xfer >= 0) begin
            since_xfer++;
            if (bus.core_start === 1'b1) begin start_lat = since_xfer; since_xfer = -1; end
            else if (since_xfer > 40) since_xfer = -1;
         end
         if (abort && bus.out_valid === 1'b1) begin
            #2 reset = 1'b1;
            #1;
            any_out = bus.req_ready | bus.blk_ready | bus.out_valid | (|bus.out_data) | (|bus.core_opmode) |
                      bus.core_start | (|bus.core_textin) | bus.tag_valid | (|bus.tag_out) | bus.auth_ok | bus.err_timeout;
            n_checks++;
            if (any_out !== 1'b0) $display("FAIL async_reset_outputs some output nonzero (out_valid=%b opmode=%h)", bus.out_valid, bus.core_opmode);
            else n_pass++;
            cm_kill = 1'b1;
            @(negedge eph1);
            @(negedge eph1);
            reset = 1'b0;
            cm_kill = 1'b0;
            bus.blk_valid = 1'b0;
            bus.out_ready = 1'b0;
            done = 1;
         end else begin
            // block source
            if (bus.blk_ready === 1'b1 && bi >= msg) extra_rdy++;
            bus.blk_valid = (bi < msg) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            bus.blk_data  = (bi < msg) ? blocks[bi] : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (bus.blk_valid && bus.blk_ready === 1'b1) begin bi++; nblk++; end
            // result sink
            if (stall && oi == 0 && bus.out_valid === 1'b1 && stall_cnt < 20) begin
               if (stall_cnt == 0) held = bus.out_data;
               else if (bus.out_data !== held) stall_bad++;
               if (bus.core_start === 1'b1) stall_bad++;
               stall_cnt++;
               bus.out_ready = 1'b0;
            end else begin
               bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
               n_checks++;
               if (oi >= msg) $display("FAIL out_extra block %0d data %h, need only %0d blocks", oi, bus.out_data, msg);
               else if (bus.out_data !== exp_out[oi]) $display("FAIL out_data[%0d] got %h need %h", oi, bus.out_data, exp_out[oi]);
               else n_pass++;
               oi++;
               if (stall && oi == 1) since_xfer = 0;
            end
            // tag
            if (bus.tag_valid === 1'b1) begin
               ntag++;
               seen_tag = 1;
               n_checks++;
               if (bus.tag_out !== exp_tag) $display("FAIL tag_out got %h need %h", bus.tag_out, exp_tag);
               else n_pass++;
               n_checks++;
               if (bus.auth_ok !== exp_auth) $display("FAIL auth_ok got %b need %b (dec=%0d)", bus.auth_ok, exp_auth, dec);
               else n_pass++;
            end else if (seen_tag) begin
               n_checks++;
               if (bus.req_ready !== 1'b1 || bus.core_opmode !== 4'h0)
                  $display("FAIL back_to_idle req_ready=%b opmode=%h need 1/0", bus.req_ready, bus.core_opmode);
               else n_pass++;
               done = 1;
            end
            @(negedge eph1);
            cyc++;
         end
      end
      bus.blk_valid = 1'b0;
      bus.out_ready = 1'b0;

      if (!abort) begin
         n_checks++;
         if (!done) $display("FAIL txn_budget transaction did not finish in %0d cycles", cyc);
         else n_pass++;
         ops_ok = (op_log.size() == exp_ops.size());
         if (ops_ok) for (int i = 0; i < exp_ops.size(); i++) if (op_log[i] !== exp_ops[i]) ops_ok = 0;
         n_checks++;
         if (!ops_ok) begin
            $display("FAIL opmode_seq got %0d starts need %0d (dec=%0d ad=%0d msg=%0d)", op_log.size(), exp_ops.size(), dec, ad, msg);
            for (int i = 0; i < op_log.size() && i < 16; i++) $display("  start %0d opmode %h", i, op_log[i]);
         end else n_pass++;
         n_checks++;
         if (oi != msg) $display("FAIL out_count got %0d need %0d", oi, msg);
         else n_pass++;
         n_checks++;
         if (nblk != msg || extra_rdy != 0) $display("FAIL blk_count got %0d accepts, %0d stray ready cycles; need %0d, 0", nblk, extra_rdy, msg);
         else n_pass++;
         n_checks++;
         if (ntag != 1) $display("FAIL tag_pulse got %0d tag_valid cycles need 1", ntag);
         else n_pass++;
         if (stall) begin
            n_checks++;
            if (stall_bad != 0 || stall_cnt != 20) $display("FAIL stall_hold got %0d violations over %0d cycles need 0 over 20", stall_bad, stall_cnt);
            else n_pass++;
            n_checks++;
            if (start_lat != 2) $display("FAIL stall_restart got start %0d cycles after transfer need 2", start_lat);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge eph1);
      n_checks++;
      if (bus.req_ready !== 1'b0 || bus.core_start !== 1'b0 || bus.out_valid !== 1'b0 || bus.core_opmode !== 4'h0)
         $display("FAIL reset_outputs req_ready=%b start=%b out_valid=%b opmode=%h need all 0", bus.req_ready, bus.core_start, bus.out_valid, bus.core_opmode);
      else n_pass++;
      n_checks++;
      if (bus.err_timeout !== 1'b0 || bus.tag_valid !== 1'b0 || bus.blk_ready !== 1'b0)
         $display("FAIL reset_flags err=%b tag_valid=%b blk_ready=%b need 0", bus.err_timeout, bus.tag_valid, bus.blk_ready);
      else n_pass++;
      reset = 1'b0;
      @(negedge eph1);
      n_checks++;
      if (bus.req_ready !== 1'b1) $display("FAIL idle_after_reset req_ready=%b need 1", bus.req_ready);
      else n_pass++;
   endtask

   task automatic test_encrypt_basic();
      rand_blocks();
      run_txn(1'b0, 1, 1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_encrypt_multi();
      for (int i = 0; i < 3; i++) blocks[i] = BLK_TP;
      run_txn(1'b0, 2, 3, calc_tag(3), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_decrypt_auth();
      logic [127:0] t;
      rand_blocks();
      t = calc_tag(2);
      run_txn(1'b1, 1, 2, t, 1'b0, 1'b0, 1'b0);
      run_txn(1'b1, 1, 2, t ^ (128'h1 << $urandom_range(0, 127)), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_stall();
      rand_blocks();
      run_txn(1'b0, 1, 2, 128'h0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_timeout();
      int cyc, start_at;
      hang_nonce = 1'b1;
      @(negedge eph1);
      cyc = 0;
      while (bus.req_ready !== 1'b1 && cyc < 50) begin @(negedge eph1); cyc++; end
      bus.req_valid    = 1'b1;
      bus.req_decrypt  = 1'b0;
      bus.req_ad_blks  = CW'(1);
      bus.req_msg_blks = CW'(1);
      @(negedge eph1);
      bus.req_valid = 1'b0;
      cyc = 0;
      start_at = -1;
      while (bus.err_timeout !== 1'b1 && cyc < 1000) begin
         if (bus.core_start === 1'b1 && bus.core_opmode === 4'h2) start_at = cyc;
         @(negedge eph1);
         cyc++;
      end
      n_checks++;
      if (bus.err_timeout !== 1'b1 || start_at < 0 || (cyc - start_at) < TMO || (cyc - start_at) > TMO + 2)
         $display("FAIL timeout_delay err=%b after %0d cycles from nonce start, need 1 after %0d..%0d", bus.err_timeout, cyc - start_at, TMO, TMO + 2);
      else n_pass++;
      n_checks++;
      if (bus.req_ready !== 1'b1 || bus.core_opmode !== 4'h0 || bus.out_valid !== 1'b0)
         $display("FAIL timeout_idle req_ready=%b opmode=%h out_valid=%b need 1/0/0", bus.req_ready, bus.core_opmode, bus.out_valid);
      else n_pass++;
      hang_nonce = 1'b0;
      repeat (3) @(negedge eph1);
      n_checks++;
      if (bus.err_timeout !== 1'b1) $display("FAIL timeout_sticky err=%b need 1", bus.err_timeout);
      else n_pass++;
      rand_blocks();
      run_txn(1'b0, 0, 1, 128'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midcrypt();
      rand_blocks();
      run_txn(1'b0, 1, 2, 128'h0, 1'b0, 1'b0, 1'b1);
      run_txn(1'b0, 0, 0, 128'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      bit dec;
      int ad, msg;
      logic [127:0] t;
      for (int k = 0; k < 6; k++) begin
         rand_blocks();
         dec = 1'($urandom_range(0, 1));
         ad  = $urandom_range(0, 3);
         msg = $urandom_range(0, 3);
         t   = $urandom_range(0, 1) ? calc_tag(msg) : {$urandom, $urandom, $urandom, $urandom};
         run_txn(dec, ad, msg, t, 1'b1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      reset            = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_decrypt  = 1'b0;
      bus.req_ad_blks  = '0;
      bus.req_msg_blks = '0;
      bus.req_tag      = '0;
      bus.blk_valid    = 1'b0;
      bus.blk_data     = '0;
      bus.out_ready    = 1'b0;
      test_reset();
      test_encrypt_basic();
      test_encrypt_multi();
      test_decrypt_auth();
      test_stall();
      test_timeout();
      test_reset_midcrypt();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
